// File: rtl/eqv_output_checker_pkg.sv
// Shared types, constants and the 32-bit fold used by the equivalence output checker.
// EQCHK_XPROP_EN: when defined, fold32 treats X/Z input bits as 0.
package eqv_check_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [31:0] MISR_POLY       = 32'h0040_0007;
   localparam int          DEF_Y_W         = 99;
   localparam int          DEF_NUM_SAMPLES = 20;
   localparam int          DEF_CNT_W       = 8;
   // Widest y bus the fold supports; callers zero-extend into this width.
   localparam int          FOLD_W          = 256;

   function automatic logic [31:0] fold32(input logic [FOLD_W-1:0] v);
      logic [31:0] acc;
      acc = '0;
      for (int w = 0; w < FOLD_W / 32; w++) begin
`ifdef EQCHK_XPROP_EN
         for (int b = 0; b < 32; b++) begin
            acc[b] = acc[b] ^ (v[w*32+b] === 1'b1);
         end
`else
         acc = acc ^ v[w*32 +: 32];
`endif
      end
      return acc;
   endfunction

endpackage

// File: rtl/eqv_output_checker_if.sv
// Sample stream into the checker: gold and test y buses qualified by sample_valid.
// Handshake: valid-only, no backpressure; a sample is taken on every posedge with sample_valid=1 while running.
interface eqv_output_checker_if #(
   parameter int Y_W = 99
);
   logic           sample_valid;
   logic [Y_W-1:0] y_gold;
   logic [Y_W-1:0] y_test;

   modport master (output sample_valid, output y_gold, output y_test);
   modport slave  (input  sample_valid, input  y_gold, input  y_test);
endinterface

// File: rtl/eqv_output_checker_misr32.sv
// 32-bit MISR, polynomial x^32+x^22+x^2+x+1, with synchronous clear and update enable.
module eqv_misr32
   import eqv_check_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        en,
   input  logic [31:0] data,
   output logic [31:0] sig
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig <= '0;
      end else if (clear) begin
         sig <= '0;
      end else if (en) begin
         sig <= {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ data;
      end
   end

endmodule

// File: rtl/eqv_output_checker.sv
// Lockstep gold/test y comparator: mismatch count, first-failure capture, MISR signatures, pass verdict.
// EQCHK_XPROP_EN: when defined, X/Z differences (!==) also count as mismatches.
module eqv_output_checker
   import eqv_check_pkg::*;
#(
   parameter int Y_W         = DEF_Y_W,
   parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   eqv_output_checker_if.slave  smp,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_W-1:0]     sample_count,
   output logic [CNT_W-1:0]     mismatch_count,
   output logic [CNT_W-1:0]     first_fail_idx,
   output logic [Y_W-1:0]       first_fail_xor,
   output logic [31:0]          sig_gold,
   output logic [31:0]          sig_test,
   output state_t               fsm_state
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_SAMPLES);

   state_t           state, state_nxt;
   logic             clear, accept, mism;
   logic [CNT_W-1:0] cnt_nxt, mm_nxt, idx_nxt;
   logic [Y_W-1:0]   xor_nxt, diff;
   logic             pass_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      accept    = 1'b0;
      mism      = 1'b0;
      cnt_nxt   = sample_count;
      mm_nxt    = mismatch_count;
      idx_nxt   = first_fail_idx;
      xor_nxt   = first_fail_xor;
      pass_nxt  = pass;
      diff      = smp.y_gold ^ smp.y_test;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt = ST_RUN;
               clear     = 1'b1;
               cnt_nxt   = '0;
               mm_nxt    = '0;
               idx_nxt   = '0;
               xor_nxt   = '0;
               pass_nxt  = 1'b0;
            end
         end
         ST_RUN: begin
            if (smp.sample_valid) begin
               accept  = 1'b1;
               cnt_nxt = sample_count + CNT_W'(1);
`ifdef EQCHK_XPROP_EN
               mism = (smp.y_gold !== smp.y_test);
`else
               mism = (smp.y_gold != smp.y_test);
`endif
               if (mism) begin
                  if (mismatch_count != '1) mm_nxt = mismatch_count + CNT_W'(1);
                  // First mismatch of the run: counter still zero before this sample.
                  if (mismatch_count == '0) begin
                     idx_nxt = sample_count;
                     xor_nxt = diff;
                  end
               end
            end
            if ((accept && (cnt_nxt == LAST_COUNT)) || stop) begin
               state_nxt = ST_DONE;
               pass_nxt  = (mm_nxt == '0) && (cnt_nxt == LAST_COUNT);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_count   <= '0;
         mismatch_count <= '0;
         first_fail_idx <= '0;
         first_fail_xor <= '0;
         pass           <= 1'b0;
      end else begin
         sample_count   <= cnt_nxt;
         mismatch_count <= mm_nxt;
         first_fail_idx <= idx_nxt;
         first_fail_xor <= xor_nxt;
         pass           <= pass_nxt;
      end
   end

   eqv_misr32 u_misr_gold (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .en    (accept),
      .data  (fold32(FOLD_W'(smp.y_gold))),
      .sig   (sig_gold)
   );

   eqv_misr32 u_misr_test (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .en    (accept),
      .data  (fold32(FOLD_W'(smp.y_test))),
      .sig   (sig_test)
   );

   assign busy      = (state == ST_RUN);
   assign done      = (state == ST_DONE);
   assign fsm_state = state;

endmodule

// File: tb/tb_eqv_output_checker.sv
// Directed bench for eqv_output_checker: NUM_SAMPLES=20 instance plus a 64-sample instance for long MISR runs.
module tb_eqv_output_checker;
   import eqv_check_pkg::*;

   localparam int Y_W   = 99;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst, start, stop;
   always #5 clk = ~clk;

   eqv_output_checker_if #(.Y_W(Y_W)) smp ();

   logic             a_busy, a_done, a_pass, b_busy, b_done, b_pass;
   logic [CNT_W-1:0] a_sc, a_mm, a_idx, b_sc, b_mm, b_idx;
   logic [Y_W-1:0]   a_xor, b_xor;
   logic [31:0]      a_sg, a_st, b_sg, b_st;
   state_t           a_state, b_state;

   eqv_output_checker #(.Y_W(Y_W), .NUM_SAMPLES(20), .CNT_W(CNT_W)) dut_a (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .smp(smp),
      .busy(a_busy), .done(a_done), .pass(a_pass), .sample_count(a_sc),
      .mismatch_count(a_mm), .first_fail_idx(a_idx), .first_fail_xor(a_xor),
      .sig_gold(a_sg), .sig_test(a_st), .fsm_state(a_state)
   );

   eqv_output_checker #(.Y_W(Y_W), .NUM_SAMPLES(64), .CNT_W(CNT_W)) dut_b (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .smp(smp),
      .busy(b_busy), .done(b_done), .pass(b_pass), .sample_count(b_sc),
      .mismatch_count(b_mm), .first_fail_idx(b_idx), .first_fail_xor(b_xor),
      .sig_gold(b_sg), .sig_test(b_st), .fsm_state(b_state)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [Y_W-1:0] g, input logic [Y_W-1:0] t, input logic s);
      smp.sample_valid = 1'b1;
      smp.y_gold       = g;
      smp.y_test       = t;
      stop             = s;
      tick();
      smp.sample_valid = 1'b0;
      stop             = 1'b0;
   endtask

   function automatic logic [Y_W-1:0] rand_y();
      return {3'($urandom_range(7, 0)), $urandom, $urandom, $urandom};
   endfunction

   // Bit i of y lands on fold bit i mod 32.
   function automatic logic [31:0] misr_model(input logic [31:0] s, input logic [Y_W-1:0] y);
      logic [31:0] f;
      f = '0;
      for (int i = 0; i < Y_W; i++) f[i % 32] = f[i % 32] ^ y[i];
      return {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0) ^ f;
   endfunction

   logic [Y_W-1:0] y, t;
   logic [31:0]    exp_sig;

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      smp.sample_valid = 1'b0; smp.y_gold = '0; smp.y_test = '0;
      #1;
      check("reset_busy", 128'(a_busy), 128'(0));
      check("reset_done", 128'(a_done), 128'(0));
      check("reset_pass", 128'(a_pass), 128'(0));
      check("reset_count", 128'(a_sc), 128'(0));
      check("reset_sig", 128'(a_sg), 128'(0));
      check("reset_state", 128'(a_state), 128'(ST_IDLE));
      repeat (2) tick();
      rst = 1'b0;

      // sample_valid ignored while idle
      send(99'h5, 99'h6, 1'b0);
      check("idle_ignore_count", 128'(a_sc), 128'(0));

      // 20 identical random samples
      pulse_start();
      check("run_busy", 128'(a_busy), 128'(1));
      exp_sig = '0;
      for (int i = 0; i < 20; i++) begin
         y = rand_y();
         exp_sig = misr_model(exp_sig, y);
         send(y, y, 1'b0);
      end
      check("t1_done", 128'(a_done), 128'(1));
      check("t1_busy", 128'(a_busy), 128'(0));
      check("t1_pass", 128'(a_pass), 128'(1));
      check("t1_mm", 128'(a_mm), 128'(0));
      check("t1_count", 128'(a_sc), 128'(20));
      check("t1_sig_gold", 128'(a_sg), 128'(exp_sig));
      check("t1_sig_test", 128'(a_st), 128'(exp_sig));

      // sample 5 has y_test bit 7 flipped; restart from DONE
      pulse_start();
      check("t2_clear_count", 128'(a_sc), 128'(0));
      check("t2_clear_sig", 128'(a_sg), 128'(0));
      check("t2_clear_pass", 128'(a_pass), 128'(0));
      for (int i = 0; i < 20; i++) begin
         y = rand_y();
         t = (i == 5) ? (y ^ 99'h80) : y;
         send(y, t, 1'b0);
      end
      check("t2_done", 128'(a_done), 128'(1));
      check("t2_mm", 128'(a_mm), 128'(1));
      check("t2_idx", 128'(a_idx), 128'(5));
      check("t2_xor", 128'(a_xor), 128'(99'h80));
      check("t2_pass", 128'(a_pass), 128'(0));
      check("t2_sig_differ", 128'(a_sg != a_st), 128'(1));

      // mismatches at 3 (bit 98) and 9 (bit 0)
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         y = rand_y();
         t = y;
         if (i == 3) t[98] = ~t[98];
         if (i == 9) t[0]  = ~t[0];
         send(y, t, 1'b0);
      end
      t = '0;
      t[98] = 1'b1;
      check("t3_mm", 128'(a_mm), 128'(2));
      check("t3_idx", 128'(a_idx), 128'(3));
      check("t3_xor", 128'(a_xor), 128'(t));
      check("t3_pass", 128'(a_pass), 128'(0));

      // start ignored in RUN; stop with sample 9
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         y = rand_y();
         send(y, y, 1'b0);
      end
      pulse_start();
      check("t4_start_ignored", 128'(a_sc), 128'(3));
      check("t4_still_busy", 128'(a_busy), 128'(1));
      for (int i = 3; i < 10; i++) begin
         y = rand_y();
         send(y, y, (i == 9));
      end
      check("t4_count", 128'(a_sc), 128'(10));
      check("t4_done", 128'(a_done), 128'(1));
      check("t4_pass", 128'(a_pass), 128'(0));
      check("t4_mm", 128'(a_mm), 128'(0));
      send(99'h1, 99'h2, 1'b0);
      check("t4_done_hold", 128'(a_sc), 128'(10));

      // async reset mid-run after 7 samples
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         y = rand_y();
         send(y, (i == 2) ? ~y : y, 1'b0);
      end
      check("t5_pre_count", 128'(a_sc), 128'(7));
      #2;
      rst = 1'b1;
      #1;
      check("t5_rst_count", 128'(a_sc), 128'(0));
      check("t5_rst_mm", 128'(a_mm), 128'(0));
      check("t5_rst_xor", 128'(a_xor), 128'(0));
      check("t5_rst_sig", 128'(a_sg), 128'(0));
      check("t5_rst_busy", 128'(a_busy), 128'(0));
      check("t5_rst_state", 128'(a_state), 128'(ST_IDLE));
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) send(99'h3, 99'h4, 1'b0);
      check("t5_ignore_count", 128'(a_sc), 128'(0));
      check("t5_ignore_mm", 128'(a_mm), 128'(0));
      check("t5_ignore_state", 128'(a_state), 128'(ST_IDLE));

      // MISR walk on the 64-sample instance
      pulse_start();
      send(99'h1, 99'h1, 1'b0);
      check("t6_sig_1", 128'(b_sg), 128'(32'h1));
      send(99'h0, 99'h0, 1'b0);
      check("t6_sig_2", 128'(b_sg), 128'(32'h2));
      for (int i = 0; i < 31; i++) send(99'h0, 99'h0, 1'b0);
      check("t6_sig_poly", 128'(b_sg), 128'(32'h0040_0007));
      check("t6_sig_test", 128'(b_st), 128'(32'h0040_0007));
      check("t6_count", 128'(b_sc), 128'(33));
      check("t6_busy", 128'(b_busy), 128'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/eqv_output_checker.md
Name: eqv_output_checker

Overview:
- Downstream consumer of the synthesised `top` output `y` in the equivalence-check simulation flow.
- Samples the gold (pre-synthesis) and test (post-synthesis) `y` buses in lockstep, once per accepted sample.
- Counts mismatches, latches the first failing sample, and folds both streams into 32-bit MISR signatures.
- Reports a single pass/fail verdict, replacing per-cycle `$strobe` diffing with an in-simulation check.

Parameters:
- Y_W, 99, width of the compared `y` bus (bits Y_W-1:0).
- NUM_SAMPLES, 20, number of samples in one check run.
- CNT_W, 8, width of the sample and mismatch counters.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new run; honoured only in IDLE or DONE.
- stop  input  1  abort the run early; honoured only in RUN.
- sample_valid  input  1  y_gold/y_test are valid this cycle.
- y_gold  input  Y_W  reference netlist output.
- y_test  input  Y_W  synthesised netlist output.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- pass  output  1  verdict; meaningful only while done=1.
- sample_count  output  CNT_W  samples accepted in the current run.
- mismatch_count  output  CNT_W  mismatching samples; saturates at all-ones.
- first_fail_idx  output  CNT_W  0-based index of the first mismatching sample.
- first_fail_xor  output  Y_W  y_gold^y_test at the first mismatch.
- sig_gold  output  32  MISR over y_gold.
- sig_test  output  32  MISR over y_test.

Behaviour:
- Reset (asynchronous, active-high) takes effect immediately: FSM=IDLE, every output and counter is 0. Reset mid-run discards all progress.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 clears all counters, first-fail registers and both signatures to 0, then moves to RUN.
  - sample_valid and stop are ignored.
- RUN: each cycle with sample_valid=1 the sample is accepted and, one cycle later, registered outputs reflect it.
  - sample_count increments.
  - If y_gold != y_test:
    - mismatch_count increments; it saturates at 2^CNT_W-1.
    - If this is the first mismatch: first_fail_idx is set to the pre-increment sample_count, and first_fail_xor to y_gold^y_test.
  - Both MISRs update.
  - Leave RUN for DONE when the accepted sample makes sample_count equal NUM_SAMPLES, or when stop=1.
  - stop coincident with a valid sample: the sample is accepted first, then the FSM enters DONE.
  - start is ignored in RUN.
- DONE:
  - Outputs hold their values.
  - pass = (mismatch_count==0) && (sample_count==NUM_SAMPLES); it is registered on entry to DONE.
  - start=1 clears state and re-enters RUN, identical to the IDLE behaviour.
  - sample_valid and stop are ignored.
- MISR, polynomial x^32+x^22+x^2+x+1:
  - fold(y): zero-extend y to the next multiple of 32 bits, then XOR all 32-bit words together.
  - next = {sig[30:0],1'b0} ^ (sig[31] ? 32'h0040_0007 : 0) ^ fold(y).
- Compare is two-state (!=).
- busy and done are decoded from registered state; they are never both high.

Optional Feature:
- Macro: EQCHK_XPROP_EN.
- Defined: a sample also counts as a mismatch when y_gold !== y_test, so X/Z on either side flags; fold treats X as 0.
- Undefined: the plain != compare only; an X bit yields no mismatch.

Decomposition:
- Package eqv_check_pkg holds:
  - the FSM state typedef;
  - MISR_POLY = 32'h0040_0007;
  - the default Y_W and NUM_SAMPLES constants;
  - function fold32.
- Sub-module eqv_misr32: a single MISR register with load-clear and enable, instantiated twice (gold and test).

Test Plan:
- 20 identical random samples (NUM_SAMPLES=20) -> done after the 20th, pass=1, mismatch_count=0, sig_gold==sig_test.
- Sample 5 has y_test bit 7 flipped -> mismatch_count=1, first_fail_idx=5, first_fail_xor=99'h80, pass=0, sig_gold!=sig_test.
- Mismatches at samples 3 and 9 -> mismatch_count=2, first_fail_idx=3, and first_fail_xor is from sample 3.
- stop asserted with sample 9 -> that sample is accepted, sample_count=10, done=1, pass=0.
- rst pulsed in RUN after 7 samples -> all outputs 0 with no clock edge needed; FSM=IDLE; sample_valid is ignored until start.
- MISR from 0: y_gold=1 -> sig_gold=32'h1; then y_gold=0 -> 32'h2; after 31 more zero samples -> 32'h0040_0007.
